// File: rtl/kamus_pkg.sv
// Shared types for the kamus pipeline control path: PC source select and controller FSM states.
// Drain counter width covers the full legal DRAIN_CYCLES range of 1..15.
package kamus_pkg;

   typedef enum logic [1:0] {
      ADDR_SEL_NEXT,
      ADDR_SEL_TARGET,
      ADDR_SEL_TRAP,
      ADDR_SEL_HOLD
   } instr_addr_sel_state_e;

   typedef enum logic [1:0] {
      RUN,
      LU_STALL,
      DRAIN,
      TRAP_REDIR
   } pipe_state_e;

   localparam int unsigned REG_ADDR_W  = 5;
   localparam int unsigned DRAIN_CNT_W = 4;

endpackage

// File: rtl/kamus_hazard_detect.sv
// Load-use hazard detect between the EX load and the ID consumer.
// Purely combinational; no state, no backpressure of its own.
module kamus_hazard_detect
   import kamus_pkg::*;
(
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   input  logic                  ex_valid_i,
   input  logic                  ex_is_load_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   output logic                  load_use_o
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_match = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign load_use_o = ex_valid_i && ex_is_load_i && (ex_rd_addr_i != '0) &&
                       id_valid_i && (rs1_match || rs2_match);

endmodule

// File: rtl/kamus_pipe_ctrl.sv
// Pipeline controller: load-use bubble, EX redirect, trap drain then redirect; outputs combinational
// from state and inputs. mem_busy_i stalls every stage and freezes state and drain counter.
module kamus_pipe_ctrl
   import kamus_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   input  logic                  id_trap_i,
   input  logic                  ex_valid_i,
   input  logic                  ex_is_load_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   input  logic                  ex_redirect_i,
   input  logic                  mem_busy_i,
   output logic                  if_stall_o,
   output logic                  id_stall_o,
   output logic                  ex_stall_o,
   output logic                  id_flush_o,
   output logic                  ex_flush_o,
   output instr_addr_sel_state_e instr_addr_sel_o,
   output logic [31:0]           stall_cycles_o
);

   pipe_state_e            state_q, state_d;
   logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [31:0]            stall_cnt_q;
   logic                   load_use;

   kamus_hazard_detect u_hazard_detect (
      .id_valid_i    (id_valid_i),
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_used_i (id_rs2_used_i),
      .ex_valid_i    (ex_valid_i),
      .ex_is_load_i  (ex_is_load_i),
      .ex_rd_addr_i  (ex_rd_addr_i),
      .load_use_o    (load_use)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else if (if_stall_o) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_cnt_q;

   always_comb begin
      state_d          = state_q;
      drain_cnt_d      = drain_cnt_q;
      if_stall_o       = 1'b0;
      id_stall_o       = 1'b0;
      ex_stall_o       = 1'b0;
      id_flush_o       = 1'b0;
      ex_flush_o       = 1'b0;
      instr_addr_sel_o = ADDR_SEL_NEXT;

      if (rst_i) begin
         id_flush_o       = 1'b1;
         ex_flush_o       = 1'b1;
         instr_addr_sel_o = ADDR_SEL_HOLD;
      end else if (mem_busy_i) begin
         if_stall_o       = 1'b1;
         id_stall_o       = 1'b1;
         ex_stall_o       = 1'b1;
         instr_addr_sel_o = ADDR_SEL_HOLD;
      end else if (ex_redirect_i) begin
         // Anything younger than the redirecting instruction is wrong-path, including a pending trap
         id_flush_o       = 1'b1;
         ex_flush_o       = 1'b1;
         instr_addr_sel_o = ADDR_SEL_TARGET;
         state_d          = RUN;
         drain_cnt_d      = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (id_trap_i && id_valid_i) begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
               end else if (load_use) begin
                  if_stall_o       = 1'b1;
                  id_stall_o       = 1'b1;
                  ex_flush_o       = 1'b1;
                  instr_addr_sel_o = ADDR_SEL_HOLD;
                  state_d          = LU_STALL;
               end
            end
            LU_STALL: begin
               state_d = RUN;
            end
            DRAIN: begin
               if_stall_o       = 1'b1;
               id_stall_o       = 1'b1;
               ex_flush_o       = 1'b1;
               instr_addr_sel_o = ADDR_SEL_HOLD;
               if (drain_cnt_q == '0) begin
                  state_d = TRAP_REDIR;
               end else begin
                  drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
               end
            end
            TRAP_REDIR: begin
               id_flush_o       = 1'b1;
               instr_addr_sel_o = ADDR_SEL_TRAP;
               state_d          = RUN;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kamus_pipe_ctrl.sv
// Bench for kamus_pipe_ctrl: directed hazard/redirect/trap/reset scenarios, then random traffic,
// all outputs checked every cycle against a plan-queue reference model.
module tb_kamus_pipe_ctrl;
   import kamus_pkg::*;

   localparam int unsigned DRAIN = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst;
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1_addr, id_rs2_addr;
   logic                  id_rs1_used, id_rs2_used;
   logic                  id_trap;
   logic                  ex_valid, ex_is_load;
   logic [REG_ADDR_W-1:0] ex_rd_addr;
   logic                  ex_redirect;
   logic                  mem_busy;
   logic                  if_stall, id_stall, ex_stall, id_flush, ex_flush;
   instr_addr_sel_state_e instr_addr_sel;
   logic [31:0]           stall_cycles;

   kamus_pipe_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .id_valid_i       (id_valid),
      .id_rs1_addr_i    (id_rs1_addr),
      .id_rs2_addr_i    (id_rs2_addr),
      .id_rs1_used_i    (id_rs1_used),
      .id_rs2_used_i    (id_rs2_used),
      .id_trap_i        (id_trap),
      .ex_valid_i       (ex_valid),
      .ex_is_load_i     (ex_is_load),
      .ex_rd_addr_i     (ex_rd_addr),
      .ex_redirect_i    (ex_redirect),
      .mem_busy_i       (mem_busy),
      .if_stall_o       (if_stall),
      .id_stall_o       (id_stall),
      .ex_stall_o       (ex_stall),
      .id_flush_o       (id_flush),
      .ex_flush_o       (ex_flush),
      .instr_addr_sel_o (instr_addr_sel),
      .stall_cycles_o   (stall_cycles)
   );

   // Reference model: a queue of the special cycles already committed to happen next
   typedef enum {P_BUBBLE, P_DRAIN, P_TRAP} plan_e;
   plan_e       plan[$];
   logic [31:0] exp_cnt;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          trap_seen = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle();
      rst = 1'b0; id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_trap = 1'b0;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd_addr = '0;
      ex_redirect = 1'b0; mem_busy = 1'b0;
   endtask

   // Called at negedge with inputs already driven; checks this cycle, advances the model at posedge
   task automatic step();
      logic e_ifs, e_ids, e_exs, e_idf, e_exf, hz;
      instr_addr_sel_state_e e_sel;
      e_ifs = 1'b0; e_ids = 1'b0; e_exs = 1'b0; e_idf = 1'b0; e_exf = 1'b0;
      e_sel = ADDR_SEL_NEXT;
      hz = ex_valid && ex_is_load && (ex_rd_addr != 0) && id_valid &&
           ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
      if (rst) begin
         plan.delete();
         exp_cnt = '0;
         e_idf = 1'b1; e_exf = 1'b1; e_sel = ADDR_SEL_HOLD;
      end else if (mem_busy) begin
         e_ifs = 1'b1; e_ids = 1'b1; e_exs = 1'b1; e_sel = ADDR_SEL_HOLD;
      end else if (ex_redirect) begin
         e_idf = 1'b1; e_exf = 1'b1; e_sel = ADDR_SEL_TARGET;
      end else if (plan.size() > 0) begin
         case (plan[0])
            P_DRAIN: begin e_ifs = 1'b1; e_ids = 1'b1; e_exf = 1'b1; e_sel = ADDR_SEL_HOLD; end
            P_TRAP:  begin e_idf = 1'b1; e_sel = ADDR_SEL_TRAP; end
            default: ;
         endcase
      end else if (!(id_trap && id_valid) && hz) begin
         e_ifs = 1'b1; e_ids = 1'b1; e_exf = 1'b1; e_sel = ADDR_SEL_HOLD;
      end
      #1;
      chk_eq("if_stall", 32'(if_stall), 32'(e_ifs));
      chk_eq("id_stall", 32'(id_stall), 32'(e_ids));
      chk_eq("ex_stall", 32'(ex_stall), 32'(e_exs));
      chk_eq("id_flush", 32'(id_flush), 32'(e_idf));
      chk_eq("ex_flush", 32'(ex_flush), 32'(e_exf));
      chk_eq("addr_sel", 32'(instr_addr_sel), 32'(e_sel));
      chk_eq("stall_cycles", stall_cycles, exp_cnt);
      if (instr_addr_sel == ADDR_SEL_TRAP) trap_seen++;
      @(posedge clk);
      if (!rst) begin
         if (e_ifs) exp_cnt = exp_cnt + 32'd1;
         if (mem_busy) begin
         end else if (ex_redirect) begin
            plan.delete();
         end else if (plan.size() > 0) begin
            void'(plan.pop_front());
         end else if (id_trap && id_valid) begin
            for (int i = 0; i < int'(DRAIN); i++) plan.push_back(P_DRAIN);
            plan.push_back(P_TRAP);
         end else if (hz) begin
            plan.push_back(P_BUBBLE);
         end
      end
      @(negedge clk);
   endtask

   task automatic trap_pulse();
      idle(); id_valid = 1'b1; id_trap = 1'b1;
      step();
      idle();
   endtask

   initial begin
      exp_cnt = '0;
      idle();
      rst = 1'b1;
      @(negedge clk);
      step();
      step();
      chk_eq("reset_cnt", stall_cycles, 32'd0);
      idle();
      step();

      // Load-use on rs1, then the bubble in EX
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd5;
      id_valid = 1'b1; id_rs1_addr = 5'd5; id_rs1_used = 1'b1; id_rs2_addr = 5'd9;
      step();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      step();
      idle();
      step();
      chk_eq("lu_cnt", stall_cycles, 32'd1);

      // Load to x0 never stalls
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd0;
      id_valid = 1'b1; id_rs1_addr = 5'd0; id_rs1_used = 1'b1;
      step();
      idle();
      step();
      chk_eq("x0_cnt", stall_cycles, 32'd1);

      // Redirect pulse
      ex_redirect = 1'b1;
      step();
      idle();
      step();

      // Trap: three drain cycles then one redirect
      trap_seen = 0;
      trap_pulse();
      repeat (DRAIN + 2) step();
      chk_eq("trap_issued", 32'(trap_seen), 32'd1);
      chk_eq("trap_cnt", stall_cycles, 32'd4);

      // Trap with two busy cycles inside the drain window
      trap_pulse();
      step();
      mem_busy = 1'b1;
      step();
      step();
      idle();
      repeat (DRAIN + 1) step();
      chk_eq("busy_trap_issued", 32'(trap_seen), 32'd2);
      chk_eq("busy_trap_cnt", stall_cycles, 32'd9);

      // Redirect in the second drain cycle cancels the trap
      trap_seen = 0;
      trap_pulse();
      step();
      ex_redirect = 1'b1;
      step();
      idle();
      repeat (6) step();
      chk_eq("cancel_no_trap", 32'(trap_seen), 32'd0);
      chk_eq("cancel_cnt", stall_cycles, 32'd10);

      // Reset in the middle of a drain abandons the trap
      trap_pulse();
      step();
      step();
      rst = 1'b1;
      step();
      idle();
      repeat (6) step();
      chk_eq("rst_drain_no_trap", 32'(trap_seen), 32'd0);
      chk_eq("rst_drain_cnt", stall_cycles, 32'd0);

      // Counter wrap: preload near the top, then a trap drain stalls three times
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      exp_cnt = 32'hFFFF_FFFE;
      trap_pulse();
      step();
      step();
      chk_eq("wrap_zero", stall_cycles, 32'd0);
      repeat (3) step();
      chk_eq("wrap_cnt", stall_cycles, 32'd1);

      // Random traffic on a small register range so hazards are frequent
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(0, 99) == 0);
         mem_busy    = ($urandom_range(0, 7) == 0);
         ex_redirect = ($urandom_range(0, 11) == 0);
         id_valid    = ($urandom_range(0, 4) != 0);
         id_trap     = ($urandom_range(0, 9) == 0);
         id_rs1_addr = REG_ADDR_W'($urandom_range(0, 3));
         id_rs2_addr = REG_ADDR_W'($urandom_range(0, 3));
         id_rs1_used = 1'($urandom_range(0, 1));
         id_rs2_used = 1'($urandom_range(0, 1));
         ex_valid    = ($urandom_range(0, 3) != 0);
         ex_is_load  = 1'($urandom_range(0, 1));
         ex_rd_addr  = REG_ADDR_W'($urandom_range(0, 3));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
